dtw_sdtw_engine: RTL and testbench

- Parametrised subsequence-DTW engine; successor to the fixed-length DTW core datapath.
- Holds a systolic chain of MAX_SQG_LEN cells, but the query length is chosen at run time.
- Squiggle (query) and reference streams enter over valid/ready handshakes; an FSM sequences load, run and drain.
- Emits a per-column score stream, the running best score and position, and a threshold hit flag; sits between the DMA stream unpackers and the result collector.

---
 rtl/dtw_sdtw_engine_if.sv | 59 +++++
 rtl/dtw_sdtw_engine.sv | 250 +++++++++++++++++++++++++
 tb/tb_dtw_sdtw_engine.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/dtw_sdtw_engine_if.sv
// ---------------------------------------------------------------------------
// dtw_sdtw_engine_if
// Groups the job control, squiggle/reference stream handshakes and the result
// outputs of the subsequence-DTW engine.
//   master : job/stream source (DMA unpackers, controller, testbench)
//   slave  : the engine itself
// Signals:
//   start, query_len, threshold          job control (master -> slave)
//   sqg_valid/sqg_ready/sqg_word         squiggle (query) stream
//   ref_valid/ref_ready/ref_word/last    reference stream
//   col_valid/col_score/col_pos          per-column score stream
//   best_score/best_position/hit         running best result
//   busy/done/cfg_err                    status
// ---------------------------------------------------------------------------
interface dtw_sdtw_engine_if #(
    parameter int WORD_LEN = 16,
    parameter int POS_W    = 32,
    parameter int QL_W     = 8
);
    logic                start;
    logic [QL_W-1:0]     query_len;
    logic [WORD_LEN-1:0] threshold;
    logic                sqg_valid;
    logic                sqg_ready;
    logic [WORD_LEN-1:0] sqg_word;
    logic                ref_valid;
    logic                ref_ready;
    logic [WORD_LEN-1:0] ref_word;
    logic                ref_last;
    logic                col_valid;
    logic [WORD_LEN-1:0] col_score;
    logic [POS_W-1:0]    col_pos;
    logic [WORD_LEN-1:0] best_score;
    logic [POS_W-1:0]    best_position;
    logic                hit;
    logic                busy;
    logic                done;
    logic                cfg_err;

    modport master (
        output start, query_len, threshold,
        output sqg_valid, sqg_word,
        output ref_valid, ref_word, ref_last,
        input  sqg_ready, ref_ready,
        input  col_valid, col_score, col_pos,
        input  best_score, best_position, hit,
        input  busy, done, cfg_err
    );

    modport slave (
        input  start, query_len, threshold,
        input  sqg_valid, sqg_word,
        input  ref_valid, ref_word, ref_last,
        output sqg_ready, ref_ready,
        output col_valid, col_score, col_pos,
        output best_score, best_position, hit,
        output busy, done, cfg_err
    );
endinterface

// File: rtl/dtw_sdtw_engine.sv
// ---------------------------------------------------------------------------
// dtw_sdtw_engine
// Subsequence DTW engine with a run-time query length. A systolic chain of
// MAX_SQG_LEN cells evaluates D(i,j) = |q_i - r_j| + min(up, left, diag),
// saturating at all-ones, with a free start (D(0,j) = 0). Cell L's score is
// emitted once per reference sample and the running minimum is tracked.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : dtw_sdtw_engine_if.slave (job control, streams, results, status)
//
// State table:
//   S_IDLE  | waiting for start
//   S_LOAD  | accepting L squiggle samples into q[1..L]
//   S_RUN   | accepting reference samples, one array advance per accept
//   S_DRAIN | pushing L+1 bubbles through the array to flush the last columns
//   S_DONE  | job complete, done held high until the next accepted start
// ---------------------------------------------------------------------------
module dtw_sdtw_engine #(
    parameter int WORD_LEN    = 16,
    parameter int MAX_SQG_LEN = 250,
    parameter int POS_W       = 32,
    parameter int QL_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    dtw_sdtw_engine_if.slave   bus
);

    localparam int IDX_W = (MAX_SQG_LEN > 1) ? $clog2(MAX_SQG_LEN) : 1;
    localparam logic [QL_W-1:0] MAX_LEN = QL_W'(MAX_SQG_LEN);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                w_accept_start;
    logic                w_cfg_rej;
    logic                w_sqg_ready;
    logic                w_ref_ready;
    logic                w_busy;
    logic                w_len_ok;
    logic                w_in_vld;
    logic                w_adv;

    logic [QL_W-1:0]     r_len;
    logic [QL_W-1:0]     r_ld_idx;
    logic [QL_W-1:0]     r_drain_cnt;
    logic                r_done;
    logic                r_cfg_err;
    logic                r_col_valid;
    logic [WORD_LEN-1:0] r_col_score;
    logic [POS_W-1:0]    r_col_pos;
    logic [POS_W-1:0]    r_out_pos;
    logic [WORD_LEN-1:0] r_best_score;
    logic [POS_W-1:0]    r_best_pos;

    logic [WORD_LEN-1:0] r_q     [MAX_SQG_LEN];
    logic [WORD_LEN-1:0] r_score [MAX_SQG_LEN];
    logic [WORD_LEN-1:0] r_diag  [MAX_SQG_LEN];
    logic [WORD_LEN-1:0] r_ref   [MAX_SQG_LEN];
    logic [MAX_SQG_LEN-1:0] r_vld;

    logic [WORD_LEN-1:0] w_up_score [MAX_SQG_LEN];
    logic [WORD_LEN-1:0] w_up_ref   [MAX_SQG_LEN];
    logic [MAX_SQG_LEN-1:0] w_up_vld;
    logic [WORD_LEN-1:0] w_cost     [MAX_SQG_LEN];
    logic [WORD_LEN-1:0] w_min      [MAX_SQG_LEN];
    logic [WORD_LEN:0]   w_sum      [MAX_SQG_LEN];
    logic [WORD_LEN-1:0] w_next     [MAX_SQG_LEN];

    logic [IDX_W-1:0]    w_ld_addr;
    logic [IDX_W-1:0]    w_tail_idx;
    logic [QL_W-1:0]     w_last_ld;
    logic [WORD_LEN-1:0] w_tail_score;
    logic                w_tail_vld;

    assign w_len_ok  = (bus.query_len != '0) && (bus.query_len <= MAX_LEN);
    assign w_last_ld = r_len - 1'b1;
    assign w_ld_addr = IDX_W'(r_ld_idx);
    assign w_tail_idx = IDX_W'(w_last_ld);
    assign w_tail_score = r_score[w_tail_idx];
    assign w_tail_vld   = r_vld[w_tail_idx];

    // A stalled reference stream freezes the whole array; drain never stalls.
    assign w_in_vld = (r_state == S_RUN) && bus.ref_valid;
    assign w_adv    = w_in_vld || (r_state == S_DRAIN);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_accept_start = 1'b0;
        w_cfg_rej      = 1'b0;
        w_sqg_ready    = 1'b0;
        w_ref_ready    = 1'b0;
        w_busy         = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    if (w_len_ok) begin
                        w_accept_start = 1'b1;
                        w_state_nxt    = S_LOAD;
                    end else begin
                        w_cfg_rej = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                w_sqg_ready = 1'b1;
                w_busy      = 1'b1;
                if (bus.sqg_valid && (r_ld_idx == w_last_ld)) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_ref_ready = 1'b1;
                w_busy      = 1'b1;
                if (bus.ref_valid && bus.ref_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                if (r_drain_cnt == '0) w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- query store ----------------
    always_ff @(posedge clk) begin
        if (!rst && w_sqg_ready && bus.sqg_valid) r_q[w_ld_addr] <= bus.sqg_word;
    end

    // ---------------- systolic cells ----------------
    // Cell c holds query index c+1. Its upstream is cell c-1, or for cell 0
    // the incoming reference with the free-start row D(0,j) = 0.
    always_comb begin
        w_up_score[0] = '0;
        w_up_ref[0]   = bus.ref_word;
        w_up_vld[0]   = w_in_vld;
        for (int c = 1; c < MAX_SQG_LEN; c++) begin
            w_up_score[c] = r_score[c-1];
            w_up_ref[c]   = r_ref[c-1];
            w_up_vld[c]   = r_vld[c-1];
        end
    end

    always_comb begin
        for (int c = 0; c < MAX_SQG_LEN; c++) begin
            w_cost[c] = (r_q[c] >= w_up_ref[c]) ? (r_q[c] - w_up_ref[c])
                                                : (w_up_ref[c] - r_q[c]);
            w_min[c]  = (w_up_score[c] < r_score[c]) ? w_up_score[c] : r_score[c];
            if (r_diag[c] < w_min[c]) w_min[c] = r_diag[c];
            w_sum[c]  = {1'b0, w_cost[c]} + {1'b0, w_min[c]};
            w_next[c] = w_sum[c][WORD_LEN] ? '1 : w_sum[c][WORD_LEN-1:0];
        end
    end

    // r_score holds D(i,j-1) (left) until the next column arrives; r_diag keeps
    // the upstream score consumed last time, which is D(i-1,j-1) for column j.
    always_ff @(posedge clk) begin
        if (rst || w_accept_start) begin
            r_vld <= '0;
            for (int c = 0; c < MAX_SQG_LEN; c++) begin
                r_score[c] <= '1;
                r_diag[c]  <= '1;
                r_ref[c]   <= '0;
            end
        end else if (w_adv) begin
            r_vld <= w_up_vld;
            for (int c = 0; c < MAX_SQG_LEN; c++) begin
                if (w_up_vld[c]) begin
                    r_score[c] <= w_next[c];
                    r_diag[c]  <= w_up_score[c];
                    r_ref[c]   <= w_up_ref[c];
                end
            end
        end
    end

    // ---------------- control counters, column output, best tracking ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len        <= QL_W'(1);
            r_ld_idx     <= '0;
            r_drain_cnt  <= '0;
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_col_valid  <= 1'b0;
            r_col_score  <= '0;
            r_col_pos    <= '0;
            r_out_pos    <= '0;
            r_best_score <= '1;
            r_best_pos   <= '0;
        end else begin
            r_cfg_err   <= w_cfg_rej;
            r_col_valid <= 1'b0;
            if (w_accept_start) begin
                r_len        <= bus.query_len;
                r_ld_idx     <= '0;
                r_drain_cnt  <= '0;
                r_done       <= 1'b0;
                r_col_score  <= '0;
                r_col_pos    <= '0;
                r_out_pos    <= '0;
                r_best_score <= '1;
                r_best_pos   <= '0;
            end else begin
                if (w_sqg_ready && bus.sqg_valid) r_ld_idx <= r_ld_idx + 1'b1;

                // Loading L gives L+1 drain cycles (counts L..0).
                if ((r_state == S_RUN) && (w_state_nxt == S_DRAIN))
                    r_drain_cnt <= r_len;
                else if ((r_state == S_DRAIN) && (r_drain_cnt != '0))
                    r_drain_cnt <= r_drain_cnt - 1'b1;

                if ((r_state == S_DRAIN) && (w_state_nxt == S_DONE)) r_done <= 1'b1;

                // Columns leave cell L in order, so a single output counter gives j.
                if (w_adv && w_tail_vld) begin
                    r_col_valid <= 1'b1;
                    r_col_score <= w_tail_score;
                    r_col_pos   <= r_out_pos;
                    if (r_out_pos != '1) r_out_pos <= r_out_pos + 1'b1;
                end

                if (r_col_valid && (r_col_score < r_best_score)) begin
                    r_best_score <= r_col_score;
                    r_best_pos   <= r_col_pos;
                end
            end
        end
    end

    assign bus.sqg_ready     = w_sqg_ready;
    assign bus.ref_ready     = w_ref_ready;
    assign bus.busy          = w_busy;
    assign bus.done          = r_done;
    assign bus.cfg_err       = r_cfg_err;
    assign bus.col_valid     = r_col_valid;
    assign bus.col_score     = r_col_score;
    assign bus.col_pos       = r_col_pos;
    assign bus.best_score    = r_best_score;
    assign bus.best_position = r_best_pos;
    assign bus.hit           = (r_best_score <= bus.threshold);

endmodule

// File: tb/tb_dtw_sdtw_engine.sv
module tb_dtw_sdtw_engine;
    localparam int WL   = 8;
    localparam int MAXL = 4;
    localparam int PW   = 16;
    localparam int QW   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_stall_viol = 0;
    bit   prev_adv = 1'b0;
    int   col_q[$];
    int   pos_q[$];

    always #5 clk = ~clk;

    dtw_sdtw_engine_if #(.WORD_LEN(WL), .POS_W(PW), .QL_W(QW)) bus ();

    dtw_sdtw_engine #(
        .WORD_LEN(WL), .MAX_SQG_LEN(MAXL), .POS_W(PW), .QL_W(QW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Column collector; a column may only appear right after a cycle in which
    // the array advanced (accepted reference or drain cycle).
    always @(negedge clk) begin
        if (bus.col_valid) begin
            col_q.push_back(int'(bus.col_score));
            pos_q.push_back(int'(bus.col_pos));
            if (!prev_adv) n_stall_viol++;
        end
        prev_adv = (bus.ref_ready && bus.ref_valid) ||
                   (bus.busy && !bus.sqg_ready && !bus.ref_ready);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic start_job(input int len);
        bus.query_len = QW'(len);
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic load_query(input int qv[8], input int len);
        int guard;
        for (int k = 0; k < len; k++) begin
            bus.sqg_valid = 1'b1;
            bus.sqg_word  = WL'(qv[k]);
            guard = 0;
            while (!bus.sqg_ready && guard < 50) begin
                tick();
                guard++;
            end
            if (!bus.sqg_ready) check("sqg_ready_timeout", 0, 1);
            tick();
        end
        bus.sqg_valid = 1'b0;
    endtask

    task automatic send_refs(input int rv[8], input int nr, input int stall, input int start_at);
        int guard;
        for (int k = 0; k < nr; k++) begin
            if (stall != 0) begin
                bus.ref_valid = 1'b0;
                tick();
            end
            bus.ref_valid = 1'b1;
            bus.ref_word  = WL'(rv[k]);
            bus.ref_last  = (k == nr - 1);
            if (k == start_at) begin
                bus.start     = 1'b1;
                bus.query_len = QW'(2);
            end
            guard = 0;
            while (!bus.ref_ready && guard < 50) begin
                tick();
                guard++;
            end
            if (!bus.ref_ready) check("ref_ready_timeout", 0, 1);
            tick();
            if (k == start_at) begin
                bus.start = 1'b0;
                check("start_in_run_busy", int'(bus.busy), 1);
                check("start_in_run_cfg_err", int'(bus.cfg_err), 0);
            end
        end
        bus.ref_valid = 1'b0;
        bus.ref_last  = 1'b0;
    endtask

    task automatic run_job(input string name, input int len, input int qv[8], input int rv[8],
                           input int nr, input int stall, input int start_at, input int thr,
                           input int ec[8], input int exp_best, input int exp_pos, input int exp_hit);
        int guard;
        col_q.delete();
        pos_q.delete();
        n_stall_viol = 0;
        bus.threshold = WL'(thr);
        start_job(len);
        load_query(qv, len);
        send_refs(rv, nr, stall, start_at);
        guard = 0;
        while (!bus.done && guard < 100) begin
            tick();
            guard++;
        end
        check({name, "_done"}, int'(bus.done), 1);
        check({name, "_ncols"}, col_q.size(), nr);
        for (int k = 0; k < nr && k < col_q.size(); k++) begin
            check($sformatf("%s_col%0d", name, k), col_q[k], ec[k]);
            check($sformatf("%s_pos%0d", name, k), pos_q[k], k);
        end
        check({name, "_best_score"}, int'(bus.best_score), exp_best);
        check({name, "_best_pos"}, int'(bus.best_position), exp_pos);
        check({name, "_hit"}, int'(bus.hit), exp_hit);
        check({name, "_stall_cols"}, n_stall_viol, 0);
        check({name, "_busy"}, int'(bus.busy), 0);
    endtask

    initial begin
        int qv[8];
        int rv[8];
        int ec[8];

        bus.start = 1'b0; bus.query_len = '0; bus.threshold = WL'(254);
        bus.sqg_valid = 1'b0; bus.sqg_word = '0;
        bus.ref_valid = 1'b0; bus.ref_word = '0; bus.ref_last = 1'b0;
        rst = 1'b1;
        tick();
        tick();

        check("rst_best_score", int'(bus.best_score), 255);
        check("rst_best_pos", int'(bus.best_position), 0);
        check("rst_col_score", int'(bus.col_score), 0);
        check("rst_col_pos", int'(bus.col_pos), 0);
        check("rst_col_valid", int'(bus.col_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_sqg_ready", int'(bus.sqg_ready), 0);
        check("rst_ref_ready", int'(bus.ref_ready), 0);
        check("rst_cfg_err", int'(bus.cfg_err), 0);
        check("rst_hit", int'(bus.hit), 0);
        rst = 1'b0;
        tick();

        qv = '{10, 20, 30, 0, 0, 0, 0, 0};
        rv = '{0, 10, 20, 30, 0, 0, 0, 0};
        ec = '{60, 30, 10, 0, 30, 0, 0, 0};
        run_job("basic", 3, qv, rv, 5, 0, -1, 0, ec, 0, 3, 1);
        run_job("stall", 3, qv, rv, 5, 1, -1, 0, ec, 0, 3, 1);

        qv = '{255, 255, 255, 0, 0, 0, 0, 0};
        rv = '{0, 0, 0, 0, 0, 0, 0, 0};
        ec = '{255, 255, 0, 0, 0, 0, 0, 0};
        run_job("sat", 3, qv, rv, 2, 0, -1, 254, ec, 255, 0, 0);

        qv = '{5, 0, 0, 0, 0, 0, 0, 0};
        rv = '{5, 7, 5, 0, 0, 0, 0, 0};
        ec = '{0, 2, 0, 0, 0, 0, 0, 0};
        run_job("len1", 1, qv, rv, 3, 0, -1, 0, ec, 0, 0, 1);

        do_reset();
        start_job(0);
        check("len0_cfg_err", int'(bus.cfg_err), 1);
        check("len0_busy", int'(bus.busy), 0);
        check("len0_sqg_ready", int'(bus.sqg_ready), 0);
        tick();
        check("len0_cfg_err_pulse", int'(bus.cfg_err), 0);
        start_job(5);
        check("len5_cfg_err", int'(bus.cfg_err), 1);
        check("len5_busy", int'(bus.busy), 0);
        check("len5_sqg_ready", int'(bus.sqg_ready), 0);
        tick();
        check("len5_cfg_err_pulse", int'(bus.cfg_err), 0);

        qv = '{10, 20, 30, 0, 0, 0, 0, 0};
        rv = '{0, 10, 20, 30, 0, 0, 0, 0};
        ec = '{60, 30, 10, 0, 30, 0, 0, 0};
        run_job("start_in_run", 3, qv, rv, 5, 0, 2, 0, ec, 0, 3, 1);

        bus.threshold = WL'(254);
        start_job(3);
        load_query(qv, 3);
        bus.ref_valid = 1'b1;
        bus.ref_word  = WL'(0);
        bus.ref_last  = 1'b0;
        tick();
        bus.ref_word  = WL'(10);
        tick();
        rst = 1'b1;
        tick();
        col_q.delete();
        check("midrst_ref_ready", int'(bus.ref_ready), 0);
        check("midrst_sqg_ready", int'(bus.sqg_ready), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_best_score", int'(bus.best_score), 255);
        check("midrst_best_pos", int'(bus.best_position), 0);
        check("midrst_col_valid", int'(bus.col_valid), 0);
        rst = 1'b0;
        repeat (10) tick();
        bus.ref_valid = 1'b0;
        check("midrst_no_cols", col_q.size(), 0);
        check("midrst_done", int'(bus.done), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
